// File: rtl/instruction_fetch_pkg.sv
// Shared definitions for the fetch stage: FSM encoding, reset constants and
// opcode values also used by the decode stage.
package instruction_fetch_pkg;

  typedef enum logic [2:0] {
    S_BOOT   = 3'd0,
    S_REQ    = 3'd1,
    S_WAIT   = 3'd2,
    S_RETIRE = 3'd3,
    S_FAULT  = 3'd4
  } fetch_state_e;

  localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;
  localparam logic [31:0] DEFAULT_PC_STEP  = 32'd4;

  // Major opcodes (instruction[6:0]) shared with decode.
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

endpackage

// File: rtl/instruction_fetch_next_pc.sv
// Next-PC select: sequential step or branch target. With IF_MISALIGN_TRAP_EN the
// raw value is passed through and flagged when misaligned; otherwise it is word-aligned.
module if_next_pc
  import instruction_fetch_pkg::*;
#(
  parameter logic [31:0] PC_STEP = DEFAULT_PC_STEP
) (
  input  logic [31:0] pc,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
`ifdef IF_MISALIGN_TRAP_EN
  output logic        misaligned,
`endif
  output logic [31:0] next_pc
);

  logic [31:0] raw_pc;

  // Wraps modulo 2^32 by construction of the 32-bit add.
  assign raw_pc = branch_taken ? branch_target : (pc + PC_STEP);

`ifdef IF_MISALIGN_TRAP_EN
  assign misaligned = (raw_pc[1:0] != 2'b00);
  assign next_pc    = raw_pc;
`else
  assign next_pc    = raw_pc & ~32'd3;
`endif

endmodule

// File: rtl/instruction_fetch.sv
// Single-outstanding instruction fetch stage: req/valid to imem, IF_kick_up to decode,
// waits for WB_kick_up before advancing. Optional trap: IF_MISALIGN_TRAP_EN.
module instruction_fetch
  import instruction_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
  parameter logic [31:0] PC_STEP  = DEFAULT_PC_STEP
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        imem_valid,
  input  logic        WB_kick_up,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  output logic [31:0] instruction,
  output logic [31:0] pc,
  output logic        IF_kick_up,
`ifdef IF_MISALIGN_TRAP_EN
  output logic        if_fault,
`endif
  output logic [2:0]  dbg_state
);

  // Handshake: imem_req is a level held from S_REQ through capture; a beat is
  // taken on a rising edge where imem_req=1 and imem_valid=1, and not otherwise.

  fetch_state_e state_q;
  logic [31:0]  pc_q;
  logic [31:0]  instr_q;
  logic         req_q;
  logic         kick_q;
  logic [31:0]  next_pc_d;

`ifdef IF_MISALIGN_TRAP_EN
  logic         fault_q;
  logic         misaligned_d;
`endif

  if_next_pc #(
    .PC_STEP (PC_STEP)
  ) u_next_pc (
    .pc            (pc_q),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
`ifdef IF_MISALIGN_TRAP_EN
    .misaligned    (misaligned_d),
`endif
    .next_pc       (next_pc_d)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_BOOT;
      pc_q    <= RESET_PC;
      instr_q <= NOP_INSTR;
      req_q   <= 1'b0;
      kick_q  <= 1'b0;
`ifdef IF_MISALIGN_TRAP_EN
      fault_q <= 1'b0;
`endif
    end else begin
      kick_q <= 1'b0;
      case (state_q)
        S_BOOT: begin
          state_q <= S_REQ;
          req_q   <= 1'b1;
        end
        S_REQ, S_WAIT: begin
          if (imem_valid) begin
            instr_q <= imem_rdata;
            req_q   <= 1'b0;
            kick_q  <= 1'b1;
            state_q <= S_RETIRE;
          end else begin
            state_q <= S_WAIT;
          end
        end
        S_RETIRE: begin
          // A retire in the presentation cycle belongs to no fetched instruction yet.
          if (WB_kick_up && !kick_q) begin
            pc_q <= next_pc_d;
`ifdef IF_MISALIGN_TRAP_EN
            if (misaligned_d) begin
              fault_q <= 1'b1;
              state_q <= S_FAULT;
            end else begin
              req_q   <= 1'b1;
              state_q <= S_REQ;
            end
`else
            req_q   <= 1'b1;
            state_q <= S_REQ;
`endif
          end
        end
        S_FAULT: begin
          state_q <= S_FAULT;
        end
        default: begin
          state_q <= S_BOOT;
          req_q   <= 1'b0;
        end
      endcase
    end
  end

  assign imem_req    = req_q;
  assign imem_addr   = pc_q;
  assign instruction = instr_q;
  assign pc          = pc_q;
  assign IF_kick_up  = kick_q;
  assign dbg_state   = state_q;
`ifdef IF_MISALIGN_TRAP_EN
  assign if_fault    = fault_q;
`endif

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed bench for instruction_fetch; build with +define+IF_MISALIGN_TRAP_EN for the trap variant.
module tb_instruction_fetch;

  logic        clk;
  logic        reset;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        imem_valid;
  logic        WB_kick_up;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic [31:0] instruction;
  logic [31:0] pc;
  logic        IF_kick_up;
  logic [2:0]  dbg_state;
`ifdef IF_MISALIGN_TRAP_EN
  logic        if_fault;
`endif

  int errors = 0;
  int checks = 0;
  logic [31:0] exp_q[$];

  instruction_fetch dut (
    .clk           (clk),
    .reset         (reset),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_rdata    (imem_rdata),
    .imem_valid    (imem_valid),
    .WB_kick_up    (WB_kick_up),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .instruction   (instruction),
    .pc            (pc),
    .IF_kick_up    (IF_kick_up),
`ifdef IF_MISALIGN_TRAP_EN
    .if_fault      (if_fault),
`endif
    .dbg_state     (dbg_state)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%h expected=%h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Retire the presented instruction; the expected next fetch address is queued.
  task automatic do_retire(input logic taken, input logic [31:0] tgt, input logic [31:0] exp_addr);
    WB_kick_up    = 1'b1;
    branch_taken  = taken;
    branch_target = tgt;
    tick();
    WB_kick_up    = 1'b0;
    branch_taken  = 1'b0;
    branch_target = 32'h0;
    check("retire_req", {31'b0, imem_req}, 32'd1);
    check("retire_addr", imem_addr, exp_addr);
    exp_q.push_back(exp_addr);
  endtask

  // Serve one fetch after 'waits' not-valid cycles; optionally pulse WB during IF_kick_up.
  task automatic do_fetch(input logic [31:0] word, input int waits, input logic wb_on_kick);
    logic [31:0] exp_addr;
    int n;
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL fetch_queue: got=empty expected=entry");
      exp_addr = imem_addr;
    end else begin
      exp_addr = exp_q.pop_front();
    end
    for (int i = 0; i < waits; i++) begin
      imem_valid = 1'b0;
      tick();
      check("wait_req", {31'b0, imem_req}, 32'd1);
      check("wait_addr", imem_addr, exp_addr);
      check("wait_kick", {31'b0, IF_kick_up}, 32'd0);
    end
    imem_valid = 1'b1;
    imem_rdata = word;
    n = 0;
    do begin
      tick();
      n++;
    end while (!IF_kick_up && n < 8);
    check("cap_kick", {31'b0, IF_kick_up}, 32'd1);
    check("cap_edges", n, 32'd1);
    check("cap_instr", instruction, word);
    check("cap_pc", pc, exp_addr);
    check("cap_req", {31'b0, imem_req}, 32'd0);
    imem_valid = 1'b0;
    imem_rdata = 32'h0;
    if (wb_on_kick) begin
      WB_kick_up    = 1'b1;
      branch_taken  = 1'b1;
      branch_target = 32'h0000_0200;
    end
    tick();
    WB_kick_up    = 1'b0;
    branch_taken  = 1'b0;
    branch_target = 32'h0;
    check("post_kick", {31'b0, IF_kick_up}, 32'd0);
    check("post_pc", pc, exp_addr);
    check("post_req", {31'b0, imem_req}, 32'd0);
    check("post_instr", instruction, word);
  endtask

  initial begin
    int n;
    reset         = 1'b1;
    imem_rdata    = 32'h0;
    imem_valid    = 1'b0;
    WB_kick_up    = 1'b0;
    branch_taken  = 1'b0;
    branch_target = 32'h0;
    repeat (3) tick();

    check("rst_pc", pc, 32'h0);
    check("rst_instr", instruction, 32'h0000_0013);
    check("rst_req", {31'b0, imem_req}, 32'd0);
    check("rst_kick", {31'b0, IF_kick_up}, 32'd0);
`ifdef IF_MISALIGN_TRAP_EN
    check("rst_fault", {31'b0, if_fault}, 32'd0);
`endif

    // Zero-wait first fetch; valid held from release must not be taken in boot.
    reset      = 1'b0;
    imem_valid = 1'b1;
    imem_rdata = 32'h0050_0093;
    tick();
    check("boot_req", {31'b0, imem_req}, 32'd1);
    check("boot_addr", imem_addr, 32'h0);
    check("boot_kick", {31'b0, IF_kick_up}, 32'd0);
    tick();
    check("first_kick", {31'b0, IF_kick_up}, 32'd1);
    check("first_instr", instruction, 32'h0050_0093);
    check("first_pc", pc, 32'h0);
    check("first_req", {31'b0, imem_req}, 32'd0);
    imem_valid = 1'b0;
    tick();
    check("first_kick_drop", {31'b0, IF_kick_up}, 32'd0);

    // Sequential retires with a 5-cycle memory stall on the first.
    do_retire(1'b0, 32'h0, 32'h0000_0004);
    do_fetch(32'h0010_0113, 5, 1'b0);
    do_retire(1'b0, 32'h0, 32'h0000_0008);
    do_fetch(32'h0020_0193, 0, 1'b0);
    do_retire(1'b0, 32'h0, 32'h0000_000C);
    do_fetch(32'h0030_0213, 2, 1'b0);
    do_retire(1'b0, 32'h0, 32'h0000_0010);
    do_fetch(32'h0040_0293, 0, 1'b0);
    do_retire(1'b0, 32'hFFFF_FFF0, 32'h0000_0014);
    do_fetch(32'h0000_006F, 1, 1'b0);
    do_retire(1'b1, 32'h0000_0040, 32'h0000_0040);

    // Spurious WB in S_WAIT, then WB coincident with IF_kick_up.
    imem_valid = 1'b0;
    tick();
    WB_kick_up    = 1'b1;
    branch_taken  = 1'b1;
    branch_target = 32'h0000_0080;
    tick();
    WB_kick_up    = 1'b0;
    branch_taken  = 1'b0;
    branch_target = 32'h0;
    check("spur_addr", imem_addr, 32'h0000_0040);
    check("spur_req", {31'b0, imem_req}, 32'd1);
    check("spur_kick", {31'b0, IF_kick_up}, 32'd0);
    do_fetch(32'h1234_5678, 0, 1'b1);

    // imem_valid while in S_RETIRE is ignored.
    imem_valid = 1'b1;
    imem_rdata = 32'hDEAD_BEEF;
    repeat (2) tick();
    check("stray_instr", instruction, 32'h1234_5678);
    check("stray_kick", {31'b0, IF_kick_up}, 32'd0);
    check("stray_pc", pc, 32'h0000_0040);
    check("stray_req", {31'b0, imem_req}, 32'd0);
    imem_valid = 1'b0;
    imem_rdata = 32'h0;

    // PC wrap at the top of the address space.
    do_retire(1'b1, 32'hFFFF_FFFC, 32'hFFFF_FFFC);
    do_fetch(32'h0000_0013, 0, 1'b0);
    do_retire(1'b0, 32'h0, 32'h0000_0000);
    do_fetch(32'h00A0_0513, 1, 1'b0);

    // Asynchronous reset in S_WAIT, then re-boot latency.
    do_retire(1'b1, 32'h0000_0100, 32'h0000_0100);
    exp_q.delete();
    imem_valid = 1'b0;
    tick();
    reset = 1'b1;
    #1;
    check("arst_req", {31'b0, imem_req}, 32'd0);
    check("arst_pc", pc, 32'h0);
    check("arst_instr", instruction, 32'h0000_0013);
    check("arst_kick", {31'b0, IF_kick_up}, 32'd0);
    tick();
    reset      = 1'b0;
    imem_valid = 1'b1;
    imem_rdata = 32'h00B0_0593;
    n = 0;
    do begin
      tick();
      n++;
    end while (!IF_kick_up && n < 10);
    check("reboot_latency", n, 32'd2);
    check("reboot_instr", instruction, 32'h00B0_0593);
    check("reboot_pc", pc, 32'h0);
    imem_valid = 1'b0;
    tick();

    // Misaligned branch target.
`ifdef IF_MISALIGN_TRAP_EN
    WB_kick_up    = 1'b1;
    branch_taken  = 1'b1;
    branch_target = 32'h0000_0042;
    tick();
    WB_kick_up    = 1'b0;
    branch_taken  = 1'b0;
    branch_target = 32'h0;
    check("trap_fault", {31'b0, if_fault}, 32'd1);
    check("trap_pc", pc, 32'h0000_0042);
    check("trap_req", {31'b0, imem_req}, 32'd0);
    imem_valid = 1'b1;
    imem_rdata = 32'hCAFE_F00D;
    WB_kick_up = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("trap_hold_req", {31'b0, imem_req}, 32'd0);
      check("trap_hold_kick", {31'b0, IF_kick_up}, 32'd0);
      check("trap_hold_fault", {31'b0, if_fault}, 32'd1);
    end
    imem_valid = 1'b0;
    WB_kick_up = 1'b0;
`else
    do_retire(1'b1, 32'h0000_0042, 32'h0000_0040);
    do_fetch(32'h00C0_0613, 1, 1'b0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin
    #200000;
    errors++;
    $display("FAIL watchdog: got=timeout expected=finish");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/instruction_fetch.md
Name: instruction_fetch

Overview:
- Upstream neighbour of the decode stage in the single-issue, non-overlapped core.
- Holds the PC and fetches one instruction at a time from instruction memory over a req/valid handshake.
- Presents the instruction word to decode with a one-cycle IF_kick_up pulse.
- Waits for the retire pulse from writeback, then selects the next PC (sequential or branch target) and fetches again.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- PC_STEP, 4, sequential PC increment in bytes.

Ports:
- clk  input  1  single clock, rising-edge.
- reset  input  1  asynchronous, active-high reset.
- imem_req  output  1  fetch request level to instruction memory.
- imem_addr  output  32  fetch address; equals pc while imem_req is high.
- imem_rdata  input  32  instruction word from memory.
- imem_valid  input  1  rdata valid; honoured only while imem_req is high.
- WB_kick_up  input  1  one-cycle retire pulse for the current instruction.
- branch_taken  input  1  redirect flag; sampled only with WB_kick_up.
- branch_target  input  32  redirect address; sampled only with WB_kick_up.
- instruction  output  32  registered instruction word for decode.
- pc  output  32  PC of the instruction currently presented.
- IF_kick_up  output  1  one-cycle pulse; instruction is valid during it.

Behaviour:
- Reset (asynchronous, active-high) forces:
  - pc=RESET_PC, instruction=32'h0000_0013 (NOP), imem_req=0, IF_kick_up=0, state=S_BOOT.
- Reset asserted mid-fetch or mid-wait aborts everything. A pending imem_valid after reset release is ignored unless imem_req is high.
- S_BOOT: one idle cycle after reset release, then S_REQ.
- S_REQ:
  - imem_req=1, imem_addr=pc; go to S_WAIT the same cycle.
  - imem_valid is already honoured here, so best-case capture occurs on the first edge.
- S_WAIT:
  - imem_req stays 1 and imem_addr stays stable until imem_valid=1 at a rising edge.
  - On that edge: instruction<=imem_rdata, imem_req<=0, IF_kick_up<=1, state<=S_RETIRE.
  - Unbounded wait; no timeout.
- Fetch latency: reset release to first IF_kick_up is 2 cycles plus memory wait cycles.
- S_RETIRE:
  - IF_kick_up is high for exactly the first cycle only. instruction and pc hold until the next capture.
  - On WB_kick_up=1: pc<=branch_taken ? branch_target : pc+PC_STEP, state<=S_REQ.
  - Next-PC arithmetic is modulo 2^32; 32'hFFFF_FFFC+4 wraps to 0.
- WB_kick_up in any state other than S_RETIRE is ignored. This includes WB_kick_up arriving in the same cycle as IF_kick_up, which does not advance the PC.
- branch_taken/branch_target without WB_kick_up are ignored.
- imem_valid outside S_REQ/S_WAIT is ignored; instruction is unchanged.
- Only one instruction is in flight; IF_kick_up never re-pulses without a new capture.

Optional Feature:
- Macro: IF_MISALIGN_TRAP_EN.
- Defined:
  - Adds output if_fault (1 bit, reset 0) and state S_FAULT.
  - If the selected next PC has [1:0]!=0, pc still loads that value, if_fault<=1 sticky, and state<=S_FAULT.
  - In S_FAULT: no further imem_req and no IF_kick_up until reset.
- Undefined:
  - No if_fault port.
  - Next-PC bits [1:0] are forced to 2'b00 before loading.

Decomposition:
- Shared package holds:
  - state encoding (S_BOOT, S_REQ, S_WAIT, S_RETIRE, S_FAULT);
  - NOP constant 32'h0000_0013;
  - default RESET_PC and PC_STEP constants;
  - opcode constants shared with decode.
- One sub-module, if_next_pc: combinational select of pc+PC_STEP vs branch_target, plus alignment check/masking under the macro.
- The FSM and registers stay in instruction_fetch.

Test Plan:
- Reset, then memory with zero-wait valid and rdata=32'h00500093 → imem_req high with addr 0 on cycle 1 after release; IF_kick_up pulses 1 cycle; instruction=32'h00500093, pc=0.
- Memory holds valid low 5 cycles → imem_req and imem_addr=0 stable 6 cycles; single IF_kick_up after capture; no early pulse.
- WB_kick_up with branch_taken=0 at pc=0x10 → next imem_addr=0x14. With branch_taken=1 and target=0x40 → next imem_addr=0x40.
- Spurious WB_kick_up in S_WAIT, plus imem_valid in S_RETIRE → pc and instruction unchanged; no extra IF_kick_up.
- pc=32'hFFFF_FFFC, sequential retire → imem_addr=0. Assert reset during S_WAIT → imem_req=0, pc=RESET_PC immediately (asynchronous).
- Branch target 0x42:
  - with IF_MISALIGN_TRAP_EN, if_fault=1 and imem_req stays 0;
  - without it, imem_addr=0x40.
